// File: rtl/serial_word_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_pkg
// Definitions shared by the serial word transmitter and the matching capture
// logic on the receive side:
//   - sw_state_t : frame state encoding (3-bit)
//   - SO_*       : serial line levels for idle, start and stop
//   - clog2()    : ceiling log2, used to size counters from parameters
// No ports.
// -----------------------------------------------------------------------------
package serial_word_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } sw_state_t;

  localparam logic SO_IDLE  = 1'b1;
  localparam logic SO_START = 1'b0;
  localparam logic SO_STOP  = 1'b1;

  // Returns ceil(log2(value)); 0 for value <= 1. Callers clamp to 1 bit.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_word_tx_bit_period_counter.sv
// -----------------------------------------------------------------------------
// bit_period_counter
// Counts clock cycles within one serial bit period of DIV cycles.
// Parameters:
//   DIV       : cycles per serial bit (>= 1)
// Ports:
//   C         : clock, rising edge
//   R         : synchronous active-high reset
//   clr       : restart the bit period (counter back to 0)
//   tick      : high in the last cycle of the current bit period
//   tick_next : high when the following cycle is the last cycle of the bit
//               period (assuming no clear); lets the owner register outputs
//               that must line up with tick
// -----------------------------------------------------------------------------
module bit_period_counter
  import serial_word_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic C,
  input  logic R,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_NEAR = CW'((DIV > 1) ? DIV - 2 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge C) begin
    if (R || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick      = (cnt == CNT_LAST);
  // With DIV=1 every cycle is the last of its bit.
  assign tick_next = (DIV == 1) ? 1'b1 : (cnt == CNT_NEAR);

endmodule

// File: rtl/serial_word_tx.sv
// -----------------------------------------------------------------------------
// serial_word_tx
// Captures a parallel word on an accepted load and sends it on one line as a
// framed stream: start bit (0), WIDTH data bits LSB first, optional even
// parity bit, stop bit (1). Every bit lasts DIV clock cycles.
//
// Build option: define SERIAL_WORD_TX_PARITY_EN to insert the parity bit
// (XOR of the captured word) between the data and the stop bit.
//
// Parameters:
//   WIDTH : data bits per frame (>= 1)
//   DIV   : clock cycles per serial bit (>= 1)
// Ports:
//   C    : clock, rising edge
//   R    : synchronous active-high reset, overrides everything
//   D    : parallel word, sampled only when a load is accepted
//   LD   : load strobe, accepted when LD && RDY at a rising edge
//   RDY  : idle and able to accept a load (registered)
//   SO   : serial line, idles high (registered)
//   BUSY : a frame is on the line (registered)
//   DONE : one-cycle pulse in the last cycle of the stop bit (registered)
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a load
// START  | start bit (line low)
// DATA   | data bits, shift_reg[0] on the line, LSB first
// PARITY | even parity bit (only with SERIAL_WORD_TX_PARITY_EN)
// STOP   | stop bit (line high), DONE in its last cycle
//
// All outputs are registered, so they are computed from the next state and
// the next shift-register contents rather than the current ones.
// -----------------------------------------------------------------------------
module serial_word_tx
  import serial_word_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  output logic             RDY,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int IW = (clog2(WIDTH + 1) < 1) ? 1 : clog2(WIDTH + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  sw_state_t        state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [WIDTH-1:0] shift_reg, shift_reg_d;
  logic             load;
  logic             clr;
  logic             tick;
  logic             tick_next;
  logic             so_d;
  logic             done_d;

  assign load = (state == IDLE) && LD && RDY;

  bit_period_counter #(
    .DIV(DIV)
  ) u_bit_period_counter (
    .C         (C),
    .R         (R),
    .clr       (clr),
    .tick      (tick),
    .tick_next (tick_next)
  );

`ifdef SERIAL_WORD_TX_PARITY_EN
  logic parity;

  // Parity is taken from the word at capture time; the shift register is
  // consumed by the time the parity bit goes out.
  always_ff @(posedge C) begin
    if (R) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^D;
    end
  end
`endif

  always_ff @(posedge C) begin
    if (R) begin
      state     <= IDLE;
      idx       <= '0;
      shift_reg <= '0;
      SO        <= SO_IDLE;
      RDY       <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      shift_reg <= shift_reg_d;
      SO        <= so_d;
      RDY       <= (state_d == IDLE);
      BUSY      <= (state_d != IDLE);
      DONE      <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    shift_reg_d = shift_reg;
    clr         = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          shift_reg_d = D;
          idx_d       = '0;
          clr         = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_reg_d = shift_reg >> 1;
          if (idx == IDX_LAST) begin
            idx_d = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    so_d = SO_IDLE;
    case (state_d)
      IDLE:   so_d = SO_IDLE;
      START:  so_d = SO_START;
      DATA:   so_d = shift_reg_d[0];
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: so_d = parity;
`endif
      STOP:   so_d = SO_STOP;
      default: so_d = SO_IDLE;
    endcase
  end

  // DONE must be high during the last stop cycle. Entering STOP restarts the
  // bit period, so that first stop cycle is also the last only when DIV=1;
  // while already in STOP the counter says whether the next cycle is last.
  always_comb begin
    done_d = 1'b0;
    if (state_d == STOP) begin
      if (state == STOP) begin
        done_d = tick_next;
      end else begin
        done_d = (DIV == 1);
      end
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_word_tx
// Drives two transmitters (DIV=4 and DIV=1, WIDTH=8) with the same stimulus and
// compares {SO,RDY,BUSY,DONE} of each every cycle against a frame-queue model:
// an accepted load turns the word into the list of line levels it must
// produce, one entry per clock cycle; the line is idle when the list is empty.
// Honours SERIAL_WORD_TX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_serial_word_tx;

  localparam int WIDTH = 8;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       C = 1'b0;
  logic       R;
  logic [7:0] D;
  logic       LD;
  logic       rdy4, so4, busy4, done4;
  logic       rdy1, so1, busy1, done1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit q4[$];
  bit q1[$];
  bit fr[$];

  always #5 C = ~C;

  serial_word_tx #(.WIDTH(WIDTH), .DIV(4)) dut4 (
    .C(C), .R(R), .D(D), .LD(LD),
    .RDY(rdy4), .SO(so4), .BUSY(busy4), .DONE(done4)
  );

  serial_word_tx #(.WIDTH(WIDTH), .DIV(1)) dut1 (
    .C(C), .R(R), .D(D), .LD(LD),
    .RDY(rdy1), .SO(so1), .BUSY(busy1), .DONE(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line levels of one frame, DIV entries per bit.
  task automatic build_frame(input logic [7:0] w, input int div);
    bit b[$];
    b = {};
    b.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) b.push_back(w[i]);
`ifdef SERIAL_WORD_TX_PARITY_EN
    b.push_back(^w);
`endif
    b.push_back(1'b1);
    fr = {};
    foreach (b[j]) repeat (div) fr.push_back(b[j]);
  endtask

  task automatic model_edge();
    bit idle4, idle1;
    idle4 = (q4.size() == 0);
    idle1 = (q1.size() == 0);
    if (R) begin
      q4 = {};
      q1 = {};
    end else begin
      if (!idle4) void'(q4.pop_front());
      if (idle4 && LD) begin
        build_frame(D, 4);
        q4 = fr;
      end
      if (!idle1) void'(q1.pop_front());
      if (idle1 && LD) begin
        build_frame(D, 1);
        q1 = fr;
      end
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic [3:0] e4, e1;
    @(posedge C);
    model_edge();
    #1;
    cyc++;
    e4 = (q4.size() == 0) ? 4'b1100 : {q4[0], 1'b0, 1'b1, (q4.size() == 1)};
    e1 = (q1.size() == 0) ? 4'b1100 : {q1[0], 1'b0, 1'b1, (q1.size() == 1)};
    chk($sformatf("div4 {so,rdy,busy,done} cyc%0d", cyc), {so4, rdy4, busy4, done4}, e4);
    chk($sformatf("div1 {so,rdy,busy,done} cyc%0d", cyc), {so1, rdy1, busy1, done1}, e1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    LD = 1'b0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("drain timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    int t;
    R  = 1'b1;
    LD = 1'b0;
    D  = 8'h00;

    // reset
    step();
    step();
    R = 1'b0;
    step();
    chk("reset so", so4, 1'b1);
    chk("reset rdy", rdy4, 1'b1);
    chk("reset busy", busy4, 1'b0);
    chk("reset done", done4, 1'b0);

    // single 0xA5 frame, with a 0xFF load attempt mid-frame
    D  = 8'hA5;
    LD = 1'b1;
    step();
    LD = 1'b0;
    D  = 8'h00;
    t  = 1;
    while (!done4 && t < 100) begin
      if (t == 10) begin
        LD = 1'b1;
        D  = 8'hFF;
      end else begin
        LD = 1'b0;
      end
      step();
      t++;
`ifdef SERIAL_WORD_TX_PARITY_EN
      if (t == 38) chk("parity bit a5", so4, 1'b0);
`endif
    end
    chk("a5 done cycle", t, 4 * (WIDTH + 2 + PAR));
    LD = 1'b0;
    step();
    chk("a5 rdy after done", rdy4, 1'b1);
    chk("a5 done cleared", done4, 1'b0);
    step();
    chk("no second frame", busy4, 1'b0);
    drain();

`ifdef SERIAL_WORD_TX_PARITY_EN
    D  = 8'h07;
    LD = 1'b1;
    step();
    LD = 1'b0;
    for (int i = 2; i <= 38; i++) step();
    chk("parity bit 07", so4, 1'b1);
    drain();
`endif

    // back-to-back: LD held, word changes after the first acceptance
    D  = 8'h01;
    LD = 1'b1;
    for (int i = 0; i < 5; i++) step();
    D = 8'h80;
    for (int i = 0; i < 45; i++) step();
    drain();

    // reset during data bit 3, then a clean 0x3C frame
    D  = 8'h5A;
    LD = 1'b1;
    step();
    LD = 1'b0;
    for (int i = 0; i < 17; i++) step();
    R = 1'b1;
    step();
    R = 1'b0;
    chk("midrst so", so4, 1'b1);
    chk("midrst rdy", rdy4, 1'b1);
    chk("midrst done", done4, 1'b0);
    step();
    chk("midrst no done", done4, 1'b0);
    D  = 8'h3C;
    LD = 1'b1;
    step();
    LD = 1'b0;
    drain();

    // random traffic, word changing every cycle, rare resets
    for (int i = 0; i < 1500; i++) begin
      D  = 8'($urandom);
      LD = ($urandom_range(0, 3) == 0);
      R  = ($urandom_range(0, 199) == 0);
      step();
    end
    R = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
